rf_param: RTL and testbench

RF_PARAM -- requirements
Module: rf_param

---
 rtl/rf_param.sv | 101 ++++++++++
 tb/tb_rf_param.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_param.sv
// rf_param: parameterised register file with two combinational read ports,
// one write port, optional write-to-read bypass, optional hardwired-zero r0,
// and a per-register busy scoreboard with a sticky double-reserve error flag.
module rf_param #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned BYPASS  = 1,
  parameter int unsigned ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read1regsel,
  input  logic [ADDR_W-1:0] read2regsel,
  input  logic [ADDR_W-1:0] writeregsel,
  input  logic [WIDTH-1:0]  writedata,
  input  logic              write,
  input  logic [ADDR_W-1:0] rsvregsel,
  input  logic              rsv,
  output logic [WIDTH-1:0]  read1data,
  output logic [WIDTH-1:0]  read2data,
  output logic              read1busy,
  output logic              read2busy,
  output logic              err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic             we;
  logic             rv;
  logic             r1_zero;
  logic             r2_zero;
  logic             r1_fwd;
  logic             r2_fwd;

  // Qualified write/reserve strobes; register 0 is untouchable when hardwired to zero
  always_comb begin
    we      = write && !((ZERO_R0 != 0) && (writeregsel == '0));
    rv      = rsv   && !((ZERO_R0 != 0) && (rsvregsel   == '0));
    r1_zero = (ZERO_R0 != 0) && (read1regsel == '0);
    r2_zero = (ZERO_R0 != 0) && (read2regsel == '0);
    r1_fwd  = (BYPASS != 0) && we && (writeregsel == read1regsel);
    r2_fwd  = (BYPASS != 0) && we && (writeregsel == read2regsel);
  end

  // Read port 1: hardwired zero, then forwarded write data, then stored value
  always_comb begin
    read1data = regs[read1regsel];
    read1busy = busy[read1regsel];
    if (r1_zero) begin
      read1data = '0;
      read1busy = 1'b0;
    end else if (r1_fwd) begin
      read1data = writedata;
      read1busy = 1'b0;
    end
  end

  // Read port 2: same priority as port 1
  always_comb begin
    read2data = regs[read2regsel];
    read2busy = busy[read2regsel];
    if (r2_zero) begin
      read2data = '0;
      read2busy = 1'b0;
    end else if (r2_fwd) begin
      read2data = writedata;
      read2busy = 1'b0;
    end
  end

  // Register storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs <= '{default: '0};
    end else if (we) begin
      regs[writeregsel] <= writedata;
    end
  end

  // Busy scoreboard: the reserve is applied after the clear so set wins on a collision
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      if (we) busy[writeregsel] <= 1'b0;
      if (rv) busy[rsvregsel]   <= 1'b1;
    end
  end

  // Sticky error: reserving an already-busy register not being written this cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (rv && busy[rsvregsel] && !(we && (writeregsel == rsvregsel))) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_param.sv
// tb_rf_param: scoreboard bench for rf_param; four instances share stimulus
// (default, no-bypass, hardwired r0, and 32-bit/16-entry).
module tb_rf_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  r1, r2, ws, rs;
  logic [31:0] wd;
  logic        write, rsv;

  logic [15:0] a_r1d, a_r2d, b_r1d, b_r2d, c_r1d, c_r2d;
  logic [31:0] d_r1d, d_r2d;
  logic        a_b1, a_b2, a_err, b_b1, b_b2, b_err;
  logic        c_b1, c_b2, c_err, d_b1, d_b2, d_err;

  always #5 clk = ~clk;

  rf_param u_a (
    .clk(clk), .rst(rst), .read1regsel(r1[2:0]), .read2regsel(r2[2:0]),
    .writeregsel(ws[2:0]), .writedata(wd[15:0]), .write(write),
    .rsvregsel(rs[2:0]), .rsv(rsv), .read1data(a_r1d), .read2data(a_r2d),
    .read1busy(a_b1), .read2busy(a_b2), .err(a_err)
  );

  rf_param #(.BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .read1regsel(r1[2:0]), .read2regsel(r2[2:0]),
    .writeregsel(ws[2:0]), .writedata(wd[15:0]), .write(write),
    .rsvregsel(rs[2:0]), .rsv(rsv), .read1data(b_r1d), .read2data(b_r2d),
    .read1busy(b_b1), .read2busy(b_b2), .err(b_err)
  );

  rf_param #(.ZERO_R0(1)) u_c (
    .clk(clk), .rst(rst), .read1regsel(r1[2:0]), .read2regsel(r2[2:0]),
    .writeregsel(ws[2:0]), .writedata(wd[15:0]), .write(write),
    .rsvregsel(rs[2:0]), .rsv(rsv), .read1data(c_r1d), .read2data(c_r2d),
    .read1busy(c_b1), .read2busy(c_b2), .err(c_err)
  );

  rf_param #(.WIDTH(32), .ADDR_W(4)) u_d (
    .clk(clk), .rst(rst), .read1regsel(r1), .read2regsel(r2),
    .writeregsel(ws), .writedata(wd), .write(write),
    .rsvregsel(rs), .rsv(rsv), .read1data(d_r1d), .read2data(d_r2d),
    .read1busy(d_b1), .read2busy(d_b2), .err(d_err)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic pop_check(input logic [31:0] got);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_underflow: got %h expected nothing", got);
    end else begin
      e = sb.pop_front();
      check_val(e.tag, got, e.val);
    end
  endtask

  task automatic idle();
    write = 1'b0;
    rsv   = 1'b0;
  endtask

  initial begin
    rst = 1'b0; r1 = '0; r2 = '0; ws = '0; rs = '0; wd = '0;
    write = 1'b0; rsv = 1'b0;

    // reset state on every output of every instance
    #2;
    for (int i = 0; i < 4; i++) begin
      push("rst_r1d", '0); push("rst_r2d", '0); push("rst_b1", '0);
      push("rst_b2", '0);  push("rst_err", '0);
    end
    pop_check(32'(a_r1d)); pop_check(32'(a_r2d)); pop_check(32'(a_b1)); pop_check(32'(a_b2)); pop_check(32'(a_err));
    pop_check(32'(b_r1d)); pop_check(32'(b_r2d)); pop_check(32'(b_b1)); pop_check(32'(b_b2)); pop_check(32'(b_err));
    pop_check(32'(c_r1d)); pop_check(32'(c_r2d)); pop_check(32'(c_b1)); pop_check(32'(c_b2)); pop_check(32'(c_err));
    pop_check(d_r1d);      pop_check(d_r2d);      pop_check(32'(d_b1)); pop_check(32'(d_b2)); pop_check(32'(d_err));
    @(negedge clk);
    rst = 1'b1;

    // basic write then read on both ports
    ws = 4'd5; wd = 32'hA5A5; write = 1'b1;
    push("wr5_a_r1", 32'hA5A5); push("wr5_a_r2", 32'hA5A5); push("wr5_b_r1", 32'hA5A5);
    @(negedge clk);
    idle(); r1 = 4'd5; r2 = 4'd5;
    #1 pop_check(32'(a_r1d)); pop_check(32'(a_r2d)); pop_check(32'(b_r1d));
    for (int i = 0; i < 8; i++) begin
      if (i != 5) begin
        r1 = 4'(i);
        push("other_zero", '0);
        #0.5 pop_check(32'(a_r1d));
      end
    end
    @(negedge clk);

    // bypass vs stored-value read during a same-cycle write
    ws = 4'd3; wd = 32'h1111; write = 1'b1;
    @(negedge clk);
    ws = 4'd3; wd = 32'h2222; write = 1'b1; r1 = 4'd3;
    push("byp_a_r1", 32'h2222); push("nobyp_b_r1", 32'h1111);
    #1 pop_check(32'(a_r1d)); pop_check(32'(b_r1d));
    @(negedge clk);
    idle();
    push("nobyp_b_r1_next", 32'h2222);
    #1 pop_check(32'(b_r1d));

    // reserve, busy, clear, and reserve+write collision
    rsv = 1'b1; rs = 4'd2;
    @(negedge clk);
    idle(); r2 = 4'd2;
    push("rsv2_a_b2", 1); push("rsv2_b_b2", 1);
    #1 pop_check(32'(a_b2)); pop_check(32'(b_b2));
    write = 1'b1; ws = 4'd2; wd = 32'h7777;
    push("fwd_a_b2", 0); push("nofwd_b_b2", 1); push("fwd_a_r2", 32'h7777); push("nofwd_b_r2", 0);
    #1 pop_check(32'(a_b2)); pop_check(32'(b_b2)); pop_check(32'(a_r2d)); pop_check(32'(b_r2d));
    @(negedge clk);
    idle();
    push("clr_a_b2", 0); push("clr_b_b2", 0); push("clr_a_r2", 32'h7777);
    #1 pop_check(32'(a_b2)); pop_check(32'(b_b2)); pop_check(32'(a_r2d));
    rsv = 1'b1; rs = 4'd2; write = 1'b1; ws = 4'd2; wd = 32'h3333;
    @(negedge clk);
    idle();
    push("coll_a_r2", 32'h3333); push("coll_a_b2", 1); push("coll_a_err", 0);
    #1 pop_check(32'(a_r2d)); pop_check(32'(a_b2)); pop_check(32'(a_err));

    // hardwired zero register
    write = 1'b1; ws = 4'd0; wd = 32'hFFFF; rsv = 1'b1; rs = 4'd0; r1 = 4'd0;
    push("z_c_r1_same", 0); push("z_c_b1_same", 0); push("z_a_r1_byp", 32'hFFFF);
    #1 pop_check(32'(c_r1d)); pop_check(32'(c_b1)); pop_check(32'(a_r1d));
    @(negedge clk);
    idle();
    push("z_c_r1", 0); push("z_c_b1", 0); push("z_c_err", 0); push("z_a_r1", 32'hFFFF); push("z_a_b1", 1);
    #1 pop_check(32'(c_r1d)); pop_check(32'(c_b1)); pop_check(32'(c_err)); pop_check(32'(a_r1d)); pop_check(32'(a_b1));

    // double reserve: excused by same-cycle write, then a real error that sticks
    r1 = 4'd4;
    rsv = 1'b1; rs = 4'd4;
    @(negedge clk);
    rsv = 1'b1; rs = 4'd4; write = 1'b1; ws = 4'd4; wd = 32'h4444;
    @(negedge clk);
    idle();
    push("rw4_a_err", 0); push("rw4_a_b1", 1); push("rw4_a_r1", 32'h4444);
    #1 pop_check(32'(a_err)); pop_check(32'(a_b1)); pop_check(32'(a_r1d));
    rsv = 1'b1; rs = 4'd4;
    @(negedge clk);
    idle();
    push("dbl_a_err", 1); push("dbl_b_err", 1);
    #1 pop_check(32'(a_err)); pop_check(32'(b_err));
    @(negedge clk);
    @(negedge clk);
    push("sticky_a_err", 1);
    #1 pop_check(32'(a_err));

    // wide instance, top register, then asynchronous reset mid-sequence
    write = 1'b1; ws = 4'd15; wd = 32'hDEADBEEF;
    @(negedge clk);
    idle(); r1 = 4'd15;
    push("w_d_r1", 32'hDEADBEEF); push("w_a_r1_r7", 32'hBEEF);
    #1 pop_check(d_r1d); pop_check(32'(a_r1d));
    #2 rst = 1'b0;
    push("arst_d_r1", 0); push("arst_a_r1", 0); push("arst_a_err", 0); push("arst_d_err", 0);
    #1 pop_check(d_r1d); pop_check(32'(a_r1d)); pop_check(32'(a_err)); pop_check(32'(d_err));
    @(negedge clk);
    write = 1'b1; ws = 4'd15; wd = 32'h12345678;
    push("arst_d_fwd", 32'h12345678);
    #1 pop_check(d_r1d);
    @(negedge clk);
    idle();
    push("arst_discard", 0);
    #1 pop_check(d_r1d);
    rst = 1'b1; write = 1'b1; ws = 4'd15; wd = 32'h5A5A5A5A;
    @(negedge clk);
    idle();
    push("resume_d_r1", 32'h5A5A5A5A);
    #1 pop_check(d_r1d);

    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover: got %0d entries expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
